// File: rtl/fpu_format_pkg.sv
// Shared IEEE-754 format constants and the output-slot state type
// used by the result packing stage.
package fpu_format_pkg;

    localparam int SP_W  = 32;
    localparam int SP_EW = 9;
    localparam int SP_SW = 23;
    localparam int DP_W  = 64;
    localparam int DP_EW = 12;
    localparam int DP_SW = 52;

    // Stored exponent fields drop the guard MSB of the incoming exponent.
    localparam logic [SP_EW-2:0] SP_EXP_ONES = '1;
    localparam logic [DP_EW-2:0] DP_EXP_ONES = '1;
    localparam logic [SP_SW-1:0] SP_SIG_ZERO = '0;
    localparam logic [DP_SW-1:0] DP_SIG_ZERO = '0;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/exc_sat_counter.sv
// 8-bit saturating event counter; a same-cycle increment beats clear.
module exc_sat_counter (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_inc,
    input  logic       i_clr,
    output logic [7:0] o_count
);

    logic [7:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= 8'h00;
        end else if (i_clr) begin
            r_count <= i_inc ? 8'h01 : 8'h00;
        end else if (i_inc && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'h01;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/final_result_packer.sv
// Final FPU stage: packs sign/exponent/significand with overflow and
// underflow overrides into a single-entry valid/ready output register.
module final_result_packer
    import fpu_format_pkg::*;
#(
    parameter int W  = SP_W,
    parameter int EW = SP_EW,
    parameter int SW = SP_SW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          sign_i,
    input  logic [EW-1:0] exp_i,
    input  logic [SW-1:0] sig_i,
    input  logic          overflow_i,
    input  logic          underflow_i,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  result_o,
    output logic          ovf_sticky_o,
    output logic          unf_sticky_o,
    input  logic          clr_flags,
    output logic [7:0]    exc_count_o
);

    slot_state_e   r_state;
    logic [W-1:0]  r_result;
    logic          r_ovf_sticky;
    logic          r_unf_sticky;

    logic          w_xfer;
    logic          w_exc;
    logic [EW-2:0] w_exp_field;
    logic [SW-1:0] w_sig_field;
    logic [W-1:0]  w_packed;
    logic          w_unused_guard;

    assign out_valid = (r_state == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign w_xfer    = in_valid && in_ready;
    assign w_exc     = overflow_i || underflow_i;

    // Guard MSB only matters to the upstream range check.
    assign w_unused_guard = exp_i[EW-1];

    // Overflow wins when both range flags are raised.
    always_comb begin
        w_exp_field = exp_i[EW-2:0];
        w_sig_field = sig_i;
        if (overflow_i) begin
            w_exp_field = '1;
            w_sig_field = '0;
        end else if (underflow_i) begin
            w_exp_field = '0;
            w_sig_field = '0;
        end
    end

    assign w_packed = {sign_i, w_exp_field, w_sig_field};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_EMPTY;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (in_valid) begin
                        r_state  <= ST_FULL;
                        r_result <= w_packed;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        if (in_valid) r_result <= w_packed;
                        else          r_state  <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_sticky <= 1'b0;
            r_unf_sticky <= 1'b0;
        end else begin
            if (w_xfer && overflow_i) r_ovf_sticky <= 1'b1;
            else if (clr_flags)       r_ovf_sticky <= 1'b0;
            if (w_xfer && underflow_i) r_unf_sticky <= 1'b1;
            else if (clr_flags)        r_unf_sticky <= 1'b0;
        end
    end

    exc_sat_counter u_exc_cnt (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_inc   (w_xfer && w_exc),
        .i_clr   (clr_flags),
        .o_count (exc_count_o)
    );

    assign result_o     = r_result;
    assign ovf_sticky_o = r_ovf_sticky;
    assign unf_sticky_o = r_unf_sticky;

endmodule

// File: tb/tb_final_result_packer.sv
// Bench for final_result_packer: directed literal cases plus random traffic
// checked every cycle against a queue-based behavioural model.
module tb_final_result_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sign_i = 1'b0;
    logic [8:0]  exp_i = '0;
    logic [22:0] sig_i = '0;
    logic        overflow_i = 1'b0;
    logic        underflow_i = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result_o;
    logic        ovf_sticky_o;
    logic        unf_sticky_o;
    logic        clr_flags = 1'b0;
    logic [7:0]  exc_count_o;

    int n_chk  = 0;
    int n_pass = 0;

    final_result_packer #(.W(32), .EW(9), .SW(23)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .sign_i       (sign_i),
        .exp_i        (exp_i),
        .sig_i        (sig_i),
        .overflow_i   (overflow_i),
        .underflow_i  (underflow_i),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result_o     (result_o),
        .ovf_sticky_o (ovf_sticky_o),
        .unf_sticky_o (unf_sticky_o),
        .clr_flags    (clr_flags),
        .exc_count_o  (exc_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // IEEE single packing from field arithmetic.
    function automatic logic [31:0] mpack(input bit s, input int e, input int sg,
                                          input bit o, input bit u);
        longint ef, sf, r;
        if (o)      begin ef = 255; sf = 0; end
        else if (u) begin ef = 0;   sf = 0; end
        else        begin ef = e % 256; sf = sg; end
        r = longint'(s) * 64'd2147483648 + ef * 64'd8388608 + sf;
        return r[31:0];
    endfunction

    // Behavioural model: queue of accepted-not-yet-consumed results.
    logic [31:0] m_q[$];
    bit          m_ovf = 0;
    bit          m_unf = 0;
    int          m_cnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_ovf = 0;
            m_unf = 0;
            m_cnt = 0;
        end else begin
            bit rdy, xf, ex;
            rdy = (m_q.size() == 0) || out_ready;
            xf  = in_valid && rdy;
            ex  = xf && (overflow_i || underflow_i);
            if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
            if (xf) m_q.push_back(mpack(sign_i, int'(exp_i), int'(sig_i), overflow_i, underflow_i));
            m_ovf = (xf && overflow_i)  ? 1'b1 : (clr_flags ? 1'b0 : m_ovf);
            m_unf = (xf && underflow_i) ? 1'b1 : (clr_flags ? 1'b0 : m_unf);
            if (clr_flags)   m_cnt = ex ? 1 : 0;
            else if (ex)     m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        end
    end

    // Compare process: mid-cycle, away from the active edge.
    always @(negedge clk) begin
        #1;
        chk("in_ready", in_ready, (m_q.size() == 0) || out_ready);
        chk("out_valid", out_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk("result_o", result_o, m_q[0]);
        if (rst) chk("result_rst", result_o, 32'h0);
        chk("ovf_sticky", ovf_sticky_o, m_ovf);
        chk("unf_sticky", unf_sticky_o, m_unf);
        chk("exc_count", exc_count_o, m_cnt[7:0]);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit v, input bit s, input logic [8:0] e, input logic [22:0] sg,
                       input bit o, input bit u);
        in_valid = v; sign_i = s; exp_i = e; sig_i = sg; overflow_i = o; underflow_i = u;
    endtask

    initial begin
        #3;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result_o, 32'h0);
        chk("rst_count", exc_count_o, 8'h00);
        chk("rst_in_ready", in_ready, 1'b1);
        #20;
        rst = 1'b0;
        cyc();

        // normal packing, single-cycle pulse
        out_ready = 1'b1;
        drv(1, 0, 9'h080, 23'h0, 0, 0);
        cyc();
        chk("norm_result", result_o, 32'h40000000);
        chk("norm_valid", out_valid, 1'b1);
        drv(0, 0, 9'h0, 23'h0, 0, 0);
        cyc();
        chk("norm_pulse_end", out_valid, 1'b0);

        // overflow -> signed infinity
        drv(1, 1, 9'h1FF, 23'h7FFFFF, 1, 0);
        cyc();
        chk("ovf_result", result_o, 32'hFF800000);
        chk("ovf_sticky_lit", ovf_sticky_o, 1'b1);
        chk("ovf_count_lit", exc_count_o, 8'd1);

        // underflow -> signed zero
        drv(1, 1, 9'h000, 23'h1234, 0, 1);
        cyc();
        chk("unf_result", result_o, 32'h80000000);
        chk("unf_sticky_lit", unf_sticky_o, 1'b1);
        chk("unf_count_lit", exc_count_o, 8'd2);

        // both flags: overflow wins
        drv(1, 0, 9'h000, 23'h1, 1, 1);
        cyc();
        chk("both_result", result_o, 32'h7F800000);
        drv(0, 0, 9'h0, 23'h0, 0, 0);
        cyc();

        // backpressure with two back-to-back inputs
        out_ready = 1'b0;
        drv(1, 0, 9'h07F, 23'h5, 0, 0);
        cyc();
        chk("bp_first", result_o, 32'h3F800005);
        drv(1, 0, 9'h081, 23'h7, 0, 0);
        #1;
        chk("bp_in_ready_low", in_ready, 1'b0);
        cyc();
        chk("bp_hold1", result_o, 32'h3F800005);
        cyc();
        chk("bp_hold2", result_o, 32'h3F800005);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", in_ready, 1'b1);
        cyc();
        chk("bp_second", result_o, 32'h40800007);
        chk("bp_second_valid", out_valid, 1'b1);
        drv(0, 0, 9'h0, 23'h0, 0, 0);
        cyc();
        chk("bp_drained", out_valid, 1'b0);

        // counter saturation, then clear racing an increment
        clr_flags = 1'b1;
        cyc();
        clr_flags = 1'b0;
        chk("clr_count", exc_count_o, 8'd0);
        drv(1, 0, 9'h1FF, 23'h0, 1, 0);
        repeat (260) cyc();
        chk("sat_count", exc_count_o, 8'hFF);
        clr_flags = 1'b1;
        cyc();
        chk("clr_inc_count", exc_count_o, 8'd1);
        chk("clr_inc_sticky", ovf_sticky_o, 1'b1);
        drv(0, 0, 9'h0, 23'h0, 0, 0);
        cyc();
        clr_flags = 1'b0;
        chk("clr_only_sticky", ovf_sticky_o, 1'b0);
        chk("clr_only_count", exc_count_o, 8'd0);

        // ignored inputs without in_valid
        drv(0, 1, 9'h1FF, 23'h0, 1, 1);
        cyc();
        chk("ign_count", exc_count_o, 8'd0);
        chk("ign_sticky", ovf_sticky_o, 1'b0);

        // async reset while FULL and stalled
        out_ready = 1'b0;
        drv(1, 0, 9'h090, 23'h3, 0, 0);
        cyc();
        drv(0, 0, 9'h0, 23'h0, 0, 0);
        cyc();
        chk("pre_rst_full", out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_result", result_o, 32'h0);
        chk("arst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        #3;
        rst = 1'b0;
        cyc();

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            drv($urandom_range(0, 9) < 6, 1'($urandom), 9'($urandom), 23'($urandom),
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
            out_ready = $urandom_range(0, 9) < 7;
            clr_flags = $urandom_range(0, 19) == 0;
            cyc();
        end
        drv(0, 0, 9'h0, 23'h0, 0, 0);
        clr_flags = 1'b0;
        repeat (3) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/final_result_packer.md
FINAL_RESULT_PACKER -- requirements
Module: final_result_packer

Interface
REQ-001 Parameter W, default 32, total result width (32 single, 64 double).
REQ-002 Parameter EW, default 9, width of the incoming exponent (9 single, 12 double), including one guard MSB.
REQ-003 Parameter SW, default 23, stored significand width (23 single, 52 double).
REQ-004 The module SHALL have one clock, and its reset SHALL be asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 in_valid  input  1  upstream result presented this cycle.
REQ-008 in_ready  output  1  block accepts input this cycle.
REQ-009 sign_i  input  1  result sign.
REQ-010 exp_i  input  EW  biased exponent from the normalization stage.
REQ-011 sig_i  input  SW  rounded significand, hidden bit removed.
REQ-012 overflow_i  input  1  exponent above max normal; comes from the exponent range check.
REQ-013 underflow_i  input  1  exponent below min normal; comes from the exponent range check.
REQ-014 out_valid  output  1  result_o holds a valid packed result.
REQ-015 out_ready  input  1  downstream consumes result_o this cycle.
REQ-016 result_o  output  W  packed IEEE-754 result {sign, exponent[EW-2:0], significand}.
REQ-017 ovf_sticky_o / unf_sticky_o  output  1 each  sticky exception flags.
REQ-018 clr_flags  input  1  synchronous clear of the sticky flags and the counter.
REQ-019 exc_count_o  output  8  saturating count of accepted exceptional results.

Function
REQ-020 The block SHALL be a single-entry output register with two states, EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-021 in_ready SHALL be combinational: in_ready = !out_valid | out_ready.
REQ-022 A transfer SHALL occur on a rising edge when in_valid & in_ready; result_o SHALL update on that edge, giving a latency of 1 cycle.
REQ-023 Transitions: EMPTY to FULL on transfer; FULL to EMPTY on out_ready & !in_valid; FULL to FULL with new data on out_ready & in_valid; FULL holds otherwise.
REQ-024 While FULL and out_ready=0, result_o SHALL remain bit-stable.
REQ-025 Normal packing (no flag): result_o = {sign_i, exp_i[EW-2:0], sig_i}.
REQ-026 On overflow_i=1, result_o SHALL be signed infinity: exponent all ones, significand 0.
REQ-027 On underflow_i=1, result_o SHALL be flush-to-zero: signed zero, exponent 0, significand 0.
REQ-028 If overflow_i and underflow_i are both 1, overflow SHALL take priority.
REQ-029 Sticky flags SHALL set only on a transfer with the matching flag; the set action SHALL win over clr_flags in the same cycle.
REQ-030 exc_count_o SHALL increment by 1 per transfer with overflow_i|underflow_i, SHALL saturate at 8'hFF, and SHALL clear on clr_flags (a same-cycle increment wins, giving 1).
REQ-031 Inputs without in_valid SHALL be ignored, with no flag or counter effect.

Reset
REQ-032 On rst, out_valid=0, result_o=0, both sticky flags=0, and exc_count_o=0, independent of clk.
REQ-033 Reset mid-operation SHALL discard any held result; in_ready SHALL read 1 while rst is asserted.

Structure
REQ-034 A shared package fpu_format_pkg SHALL hold the per-precision constants (W/EW/SW for single and double, the all-ones exponent, and the zero field) plus a 2-state enum for EMPTY/FULL.
REQ-035 The saturating exception counter SHALL be one sub-module, exc_sat_counter (8-bit, inc/clr inputs).
REQ-036 Packing and override muxing SHALL be combinational ahead of the single register stage; there SHALL be no other pipeline.

Verification
REQ-037 Single-precision normal: sign 0, exp 9'h080, sig 0, in_valid for 1 cycle, out_ready=1 -> result_o=32'h40000000 next cycle, out_valid pulses 1 cycle.
REQ-038 Overflow: sign 1, exp 9'h1FF, overflow_i=1 -> result_o=32'hFF800000, ovf_sticky_o=1, exc_count_o=1.
REQ-039 Underflow: sign 1, exp 9'h000, sig 23'h1234, underflow_i=1 -> result_o=32'h80000000, unf_sticky_o=1.
REQ-040 Backpressure: out_ready=0, two back-to-back inputs -> first result held stable, in_ready=0 until out_ready=1, second accepted on that edge, no data lost or duplicated.
REQ-041 Counter saturation and clear: 260 overflow transfers -> exc_count_o=8'hFF; clr_flags together with an overflow transfer -> count=1, ovf_sticky_o stays 1.
REQ-042 Reset while FULL with out_ready=0 -> out_valid=0, result_o=0 immediately, in_ready=1.
